// File: rtl/dm_arbiter_if.sv
// Signal bundle joining dm_arbiter to the load/store unit, the host port and the
// single data-memory port. The arbiter uses the slave view; its environment uses master.
interface dm_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_stall;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_lock;
    logic          host_gnt;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [15:0]   conflict_cnt;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  host_req, host_we, host_addr, host_wdata, host_lock,
        output host_gnt, host_rvalid, host_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output conflict_cnt
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output host_req, host_we, host_addr, host_wdata, host_lock,
        input  host_gnt, host_rvalid, host_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  conflict_cnt
    );
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing the data-memory port between the CPU load/store path
// and the host port, with a bounded host burst lock and a 2-cycle read return.
module dm_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_LOCK = 4
) (
    input logic         clk,
    input logic         reset,
    dm_arbiter_if.slave bus
);
    localparam int LW = (MAX_LOCK < 1) ? 1 : $clog2(MAX_LOCK + 1);
    localparam logic [LW-1:0] LOCK_LIMIT = LW'(MAX_LOCK);

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    owner_t        last_owner, owner_nxt;
    logic          lock_req, lock_req_nxt;
    logic [LW-1:0] lock_cnt, lock_cnt_nxt;
    logic          lock_active;
    logic          cpu_gnt, host_gnt, accept;

    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    owner_t        s1_owner;
    logic          s1_read;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    logic          cpu_rvalid, host_rvalid;
    logic [DW-1:0] cpu_rdata, host_rdata;
    logic [15:0]   conflict_cnt;

    // lock_req remembers whether the most recent host grant asked to keep priority
    assign lock_active = (last_owner == OWN_HOST) && lock_req && (lock_cnt < LOCK_LIMIT);

    always_comb begin
        cpu_gnt      = 1'b0;
        host_gnt     = 1'b0;
        owner_nxt    = last_owner;
        lock_req_nxt = lock_req;
        lock_cnt_nxt = lock_cnt;

        if (bus.cpu_req && bus.host_req) begin
            if (lock_active || last_owner == OWN_CPU) begin
                host_gnt = 1'b1;
            end else begin
                cpu_gnt = 1'b1;
            end
        end else begin
            cpu_gnt  = bus.cpu_req;
            host_gnt = bus.host_req;
        end

        if (cpu_gnt) begin
            owner_nxt    = OWN_CPU;
            lock_req_nxt = 1'b0;
        end else if (host_gnt) begin
            owner_nxt    = OWN_HOST;
            lock_req_nxt = bus.host_lock;
        end

        if (cpu_gnt || !bus.cpu_req) begin
            lock_cnt_nxt = '0;
        end else if (host_gnt && lock_active) begin
            lock_cnt_nxt = lock_cnt + LW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner <= OWN_HOST;
            lock_req   <= 1'b0;
            lock_cnt   <= '0;
        end else begin
            last_owner <= owner_nxt;
            lock_req   <= lock_req_nxt;
            lock_cnt   <= lock_cnt_nxt;
        end
    end

    assign accept    = cpu_gnt | host_gnt;
    assign sel_we    = host_gnt ? bus.host_we    : bus.cpu_we;
    assign sel_addr  = host_gnt ? bus.host_addr  : bus.cpu_addr;
    assign sel_wdata = host_gnt ? bus.host_wdata : bus.cpu_wdata;

    // Stage 1: registered memory command, tagged with owner and direction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            s1_owner  <= OWN_CPU;
            s1_read   <= 1'b0;
        end else begin
            mem_en <= accept;
            mem_we <= accept & sel_we;
            if (accept) begin
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                s1_owner  <= host_gnt ? OWN_HOST : OWN_CPU;
                s1_read   <= ~sel_we;
            end
        end
    end

    // Stage 2: capture read data and steer the response to its owner
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_rvalid  <= 1'b0;
            host_rvalid <= 1'b0;
            cpu_rdata   <= '0;
            host_rdata  <= '0;
        end else begin
            cpu_rvalid  <= mem_en && s1_read && (s1_owner == OWN_CPU);
            host_rvalid <= mem_en && s1_read && (s1_owner == OWN_HOST);
            if (mem_en && s1_read && s1_owner == OWN_CPU) begin
                cpu_rdata <= bus.mem_rdata;
            end
            if (mem_en && s1_read && s1_owner == OWN_HOST) begin
                host_rdata <= bus.mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_cnt <= '0;
        end else if (bus.cpu_req && bus.host_req && conflict_cnt != '1) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

    assign bus.cpu_gnt      = cpu_gnt;
    assign bus.cpu_stall    = bus.cpu_req & ~cpu_gnt;
    assign bus.cpu_rvalid   = cpu_rvalid;
    assign bus.cpu_rdata    = cpu_rdata;
    assign bus.host_gnt     = host_gnt;
    assign bus.host_rvalid  = host_rvalid;
    assign bus.host_rdata   = host_rdata;
    assign bus.mem_en       = mem_en;
    assign bus.mem_we       = mem_we;
    assign bus.mem_addr     = mem_addr;
    assign bus.mem_wdata    = mem_wdata;
    assign bus.conflict_cnt = conflict_cnt;
endmodule
